// File: rtl/tile_bl_wl_loader.sv
// Bitstream loader that programs one tile's flat bl/wl configuration bus word by word.
// Optional per-word even-parity checking with an ERROR state is enabled by defining CFG_PARITY_EN.
`timescale 1ns/1ps
module tile_bl_wl_loader #(
  parameter  int NUM_BITS = 160,
  parameter  int WORD_W   = 8,
  parameter  int WL_PULSE = 2,
  localparam int NW       = NUM_BITS / WORD_W,
  localparam int IW       = (NW > 1) ? $clog2(NW) : 1,
  localparam int PCW      = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                start,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
`ifdef CFG_PARITY_EN
  input  logic                cfg_parity,
`endif
  output logic [NUM_BITS-1:0] bl,
  output logic [NUM_BITS-1:0] wl,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IW-1:0]       word_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_SETUP,
    S_PULSE,
    S_HOLD,
`ifdef CFG_PARITY_EN
    S_ERROR,
`endif
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_ready;
  logic [NUM_BITS-1:0] r_bl;
  logic [NUM_BITS-1:0] r_wl;
  logic                r_busy;
  logic                r_done;
  logic [IW-1:0]       r_word_idx;
  logic [PCW-1:0]      r_pcnt;

  logic [31:0]         w_base;
  logic                w_last;
  logic                w_pulse_end;

  assign w_base      = 32'(r_word_idx) * 32'(WORD_W);
  assign w_last      = (r_word_idx == IW'(NW - 1));
  assign w_pulse_end = (r_pcnt == PCW'(WL_PULSE - 1));

`ifdef CFG_PARITY_EN
  logic r_err;
  logic w_par_bad;
  assign w_par_bad = ^{cfg_data, cfg_parity};
  assign err       = r_err;
`else
  assign err       = 1'b0;
`endif

  // The bl register doubles as the latch for the accepted word: its slice is loaded
  // at accept and held through SETUP, PULSE and HOLD, then cleared on leaving HOLD.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_bl       <= '0;
      r_wl       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_word_idx <= '0;
      r_pcnt     <= '0;
`ifdef CFG_PARITY_EN
      r_err      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_WAIT_DATA;
            r_word_idx <= '0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        S_WAIT_DATA: begin
          if (cfg_valid) begin
            r_ready <= 1'b0;
`ifdef CFG_PARITY_EN
            if (w_par_bad) begin
              r_state <= S_ERROR;
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_bl[w_base +: WORD_W] <= cfg_data;
              r_state                <= S_SETUP;
            end
`else
            r_bl[w_base +: WORD_W] <= cfg_data;
            r_state                <= S_SETUP;
`endif
          end
        end

        S_SETUP: begin
          r_wl[w_base +: WORD_W] <= '1;
          r_pcnt                 <= '0;
          r_state                <= S_PULSE;
        end

        S_PULSE: begin
          if (w_pulse_end) begin
            r_wl    <= '0;
            r_state <= S_HOLD;
          end else begin
            r_pcnt <= r_pcnt + PCW'(1);
          end
        end

        S_HOLD: begin
          r_bl <= '0;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_word_idx <= r_word_idx + IW'(1);
            r_ready    <= 1'b1;
            r_state    <= S_WAIT_DATA;
          end
        end

        S_DONE: begin
          if (start) begin
            r_state    <= S_WAIT_DATA;
            r_word_idx <= '0;
            r_done     <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

`ifdef CFG_PARITY_EN
        S_ERROR: begin
          if (start) begin
            r_state    <= S_WAIT_DATA;
            r_word_idx <= '0;
            r_err      <= 1'b0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
          r_bl    <= '0;
          r_wl    <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready = r_ready;
  assign bl        = r_bl;
  assign wl        = r_wl;
  assign busy      = r_busy;
  assign done      = r_done;
  assign word_idx  = r_word_idx;

endmodule

// File: tb/tb_tile_bl_wl_loader.sv
// Directed self-checking bench for tile_bl_wl_loader (default 160-bit, 8-bit word, 2-cycle pulse).
`timescale 1ns/1ps
module tb_tile_bl_wl_loader;

  localparam int NB  = 160;
  localparam int W   = 8;
  localparam int NWD = NB / W;
  localparam int PW  = 2;
  localparam int LOAD_CYCLES = 1 + NWD * (PW + 3);

  logic          prog_clk = 1'b0;
  logic          pReset;
  logic          start;
  logic [W-1:0]  cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
`ifdef CFG_PARITY_EN
  logic          cfg_parity;
`endif
  logic [NB-1:0] bl;
  logic [NB-1:0] wl;
  logic          busy;
  logic          done;
  logic          err;
  logic [4:0]    word_idx;

  int errors = 0;
  int checks = 0;

  tile_bl_wl_loader #(.NUM_BITS(NB), .WORD_W(W), .WL_PULSE(PW)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .start    (start),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
`ifdef CFG_PARITY_EN
    .cfg_parity(cfg_parity),
`endif
    .bl       (bl),
    .wl       (wl),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .word_idx (word_idx)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic test_reset();
    pReset = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hA5;
`ifdef CFG_PARITY_EN
    cfg_parity = 1'b0;
`endif
    tick(); tick();
    checks++;
    if ({cfg_ready, busy, done, err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {cfg_ready, busy, done, err});
    end
    checks++;
    if (bl !== '0 || wl !== '0) begin
      errors++; $display("FAIL reset_bus: got bl=%h wl=%h want 0", bl, wl);
    end
    checks++;
    if (word_idx !== 5'd0) begin
      errors++; $display("FAIL reset_idx: got %0d want 0", word_idx);
    end
    pReset = 1'b0; start = 1'b0;
    tick();
    // cfg_valid high in IDLE must be ignored
    checks++;
    if ({cfg_ready, busy, done} !== 3'b000 || bl !== '0) begin
      errors++; $display("FAIL idle_ignore_valid: got flags=%b bl=%h want 000/0", {cfg_ready, busy, done}, bl);
    end
    cfg_valid = 1'b0;
  endtask

  // Full load from IDLE or DONE. Negative arguments disable the option.
  task automatic run_load(input int stall_word, input int stall_len,
                          input int busy_start_word, input int abort_word);
    logic [NB-1:0] exp_bl;
    logic [NB-1:0] exp_wl;
    int edges;
    start = 1'b1;
    tick();
    start = 1'b0;
    edges = 1;
    for (int k = 0; k < NWD; k++) begin
      if (k == stall_word) begin
        cfg_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          checks++;
          if (cfg_ready !== 1'b1 || bl !== '0 || wl !== '0 || word_idx !== 5'(k)) begin
            errors++;
            $display("FAIL stall w%0d c%0d: got rdy=%b bl=%h wl=%h idx=%0d want 1/0/0/%0d",
                     k, s, cfg_ready, bl, wl, word_idx, k);
          end
          tick(); edges++;
        end
      end
      checks++;
      if (cfg_ready !== 1'b1 || busy !== 1'b1 || word_idx !== 5'(k) || bl !== '0 || wl !== '0) begin
        errors++;
        $display("FAIL wait w%0d: got rdy=%b busy=%b idx=%0d bl=%h wl=%h want 1/1/%0d/0/0",
                 k, cfg_ready, busy, word_idx, bl, wl, k);
      end
      cfg_valid = 1'b1;
      cfg_data  = 8'(k + 1);
`ifdef CFG_PARITY_EN
      cfg_parity = ^cfg_data;
`endif
      tick(); edges++;
      cfg_data = 8'(k + 2);
`ifdef CFG_PARITY_EN
      cfg_parity = ^cfg_data;
`endif
      exp_bl = '0; exp_bl[k*W +: W] = 8'(k + 1);
      exp_wl = '0; exp_wl[k*W +: W] = 8'hFF;
      if (k == busy_start_word) start = 1'b1;
      checks++;
      if (bl !== exp_bl || wl !== '0 || cfg_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL setup w%0d: got bl=%h wl=%h rdy=%b busy=%b want bl=%h wl=0 rdy=0 busy=1",
                 k, bl, wl, cfg_ready, busy, exp_bl);
      end
      tick(); edges++;
      start = 1'b0;
      for (int p = 0; p < PW; p++) begin
        checks++;
        if (bl !== exp_bl || wl !== exp_wl) begin
          errors++;
          $display("FAIL pulse w%0d p%0d: got bl=%h wl=%h want bl=%h wl=%h", k, p, bl, wl, exp_bl, exp_wl);
        end
        if (k == abort_word && p == 0) begin
          pReset = 1'b1;
          tick();
          pReset = 1'b0; cfg_valid = 1'b0;
          checks++;
          if (bl !== '0 || wl !== '0 || {busy, done, cfg_ready} !== 3'b000 || word_idx !== 5'd0) begin
            errors++;
            $display("FAIL abort_reset: got bl=%h wl=%h bdr=%b idx=%0d want all 0",
                     bl, wl, {busy, done, cfg_ready}, word_idx);
          end
          return;
        end
        tick(); edges++;
      end
      checks++;
      if (bl !== exp_bl || wl !== '0 || done !== 1'b0) begin
        errors++;
        $display("FAIL hold w%0d: got bl=%h wl=%h done=%b want bl=%h wl=0 done=0", k, bl, wl, done, exp_bl);
      end
      tick(); edges++;
    end
    cfg_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || edges !== LOAD_CYCLES + (stall_word >= 0 ? stall_len : 0)) begin
      errors++;
      $display("FAIL done_timing: got done=%b at cycle %0d want done=1 at %0d",
               done, edges, LOAD_CYCLES + (stall_word >= 0 ? stall_len : 0));
    end
    checks++;
    if ({busy, cfg_ready, err} !== 3'b000 || word_idx !== 5'(NWD - 1) || bl !== '0 || wl !== '0) begin
      errors++;
      $display("FAIL done_state: got bre=%b idx=%0d bl=%h wl=%h want 000/%0d/0/0",
               {busy, cfg_ready, err}, word_idx, bl, wl, NWD - 1);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_hold: got done=%b busy=%b want 1/0", done, busy);
    end
  endtask

  task automatic test_full_load();
    run_load(-1, 0, -1, -1);
  endtask

  task automatic test_backpressure();
    run_load(5, 7, -1, -1);
  endtask

  task automatic test_reset_mid_load();
    run_load(-1, 0, -1, 3);
    run_load(-1, 0, -1, -1);
  endtask

  task automatic test_restart_and_ignore();
    run_load(-1, 0, 2, -1);
    run_load(-1, 0, -1, -1);
  endtask

`ifdef CFG_PARITY_EN
  task automatic test_parity();
    pReset = 1'b1; tick(); pReset = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1; cfg_data = 8'(k + 1); cfg_parity = ^cfg_data;
      tick(); tick();
      for (int p = 0; p < PW; p++) tick();
      tick();
    end
    cfg_data = 8'h03; cfg_parity = 1'b1;
    tick();
    checks++;
    if ({err, cfg_ready, busy} !== 3'b100 || word_idx !== 5'd2 || wl !== '0 || bl !== '0) begin
      errors++;
      $display("FAIL parity_err: got erb=%b idx=%0d bl=%h wl=%h want 100/2/0/0",
               {err, cfg_ready, busy}, word_idx, bl, wl);
    end
    tick();
    checks++;
    if (err !== 1'b1 || wl !== '0 || word_idx !== 5'd2) begin
      errors++; $display("FAIL parity_hold: got err=%b wl=%h idx=%0d want 1/0/2", err, wl, word_idx);
    end
    cfg_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (err !== 1'b0 || word_idx !== 5'd0 || cfg_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL parity_restart: got err=%b idx=%0d rdy=%b busy=%b want 0/0/1/1",
               err, word_idx, cfg_ready, busy);
    end
    pReset = 1'b1; tick(); pReset = 1'b0;
  endtask
`endif

  initial begin
    pReset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
`ifdef CFG_PARITY_EN
    cfg_parity = 1'b0;
`endif
    test_reset();
    test_full_load();
    test_backpressure();
    test_reset_mid_load();
    test_restart_and_ignore();
`ifdef CFG_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
